// File: rtl/ro_puf_pkg.sv
// Shared definitions for the RO-PUF race datapath: controller states and
// default counter/select geometry.
package ro_puf_pkg;

    localparam int unsigned GOAL_DEF  = 512;
    localparam int unsigned CNT_W_DEF = 11;
    localparam int unsigned SEL_W_DEF = 4;
    localparam int unsigned CLEAR_CYC = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        RACE,
        RECORD,
        DONE
    } state_t;

endpackage

// File: rtl/ro_race_timer.sv
// Loadable saturating down-counter; o_done is high while the count sits at zero.
// Loading N gives a done flag on the (N+1)-th cycle after the load.
module ro_race_timer #(
    parameter int unsigned W = 14
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ro_race_arbiter.sv
// Race controller for a pair of RO edge counters: selects each oscillator pair,
// clears/settles/enables the counters and records which one finishes first.
module ro_race_arbiter
    import ro_puf_pkg::*;
#(
    parameter int unsigned GOAL       = GOAL_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned SEL_W      = SEL_W_DEF,
    parameter int unsigned RESP_BITS  = 8,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned TIMEOUT    = 16 * GOAL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic                 finished_a,
    input  logic                 finished_b,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 cnt_clr,
    output logic                 cnt_en,
    output logic                 busy,
    output logic [RESP_BITS-1:0] response,
    output logic                 resp_valid,
    output logic                 tie,
    output logic                 timeout_err
);

    localparam int unsigned IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;
    // A counter too narrow to reach GOAL would never finish; refuse to start.
    localparam logic CFG_OK = (GOAL < (1 << CNT_W));

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SEL_W-1:0]     r_base;
    logic [SEL_W-1:0]     r_sel_a;
    logic [SEL_W-1:0]     r_sel_b;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_bit;
    logic [RESP_BITS-1:0] r_response;
    logic                 r_tie;
    logic                 r_tout;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_tmr_load;
    logic [TMR_W-1:0]     w_tmr_val;
    logic                 w_tmr_done;
    logic                 w_enter_clear;
    logic [SEL_W-1:0]     w_base_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [SEL_W-1:0]     w_sel_a_nxt;

    ro_race_timer #(.W(TMR_W)) u_timer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_tmr_load),
        .i_val   (w_tmr_val),
        .o_done  (w_tmr_done)
    );

    assign w_accept = start & CFG_OK;
    assign w_last   = (r_idx == IDX_W'(RESP_BITS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        case (r_state)
            IDLE: if (w_accept) begin
                w_state_nxt = CLEAR;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TMR_W'(CLEAR_CYC - 1);
            end
            CLEAR: if (w_tmr_done) begin
                w_state_nxt = SETTLE;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TMR_W'(SETTLE_CYC - 1);
            end
            SETTLE: if (w_tmr_done) begin
                w_state_nxt = RACE;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TMR_W'(TIMEOUT - 1);
            end
            RACE: if (finished_a || finished_b || w_tmr_done) begin
                w_state_nxt = RECORD;
            end
            RECORD: if (w_last) begin
                w_state_nxt = DONE;
            end else begin
                w_state_nxt = CLEAR;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TMR_W'(CLEAR_CYC - 1);
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Selects are computed from the base/index that will be current in CLEAR.
    assign w_enter_clear = (w_state_nxt == CLEAR) && (r_state != CLEAR);
    assign w_base_nxt    = (r_state == IDLE) ? challenge : r_base;
    assign w_idx_nxt     = (r_state == IDLE) ? '0 : r_idx + IDX_W'(1);
    assign w_sel_a_nxt   = w_base_nxt + SEL_W'({w_idx_nxt, 1'b0});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_sel_a    <= '0;
            r_sel_b    <= '0;
            r_idx      <= '0;
            r_bit      <= 1'b0;
            r_response <= '0;
            r_tie      <= 1'b0;
            r_tout     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_accept) begin
                r_base <= challenge;
                r_idx  <= '0;
                r_tie  <= 1'b0;
                r_tout <= 1'b0;
            end
            if (w_enter_clear) begin
                r_sel_a <= w_sel_a_nxt;
                r_sel_b <= w_sel_a_nxt + SEL_W'(1);
            end
            if (r_state == RACE) begin
                r_bit <= finished_a & ~finished_b;
                if (finished_a && finished_b) begin
                    r_tie <= 1'b1;
                end
                if (!finished_a && !finished_b && w_tmr_done) begin
                    r_tout <= 1'b1;
                end
            end
            if (r_state == RECORD) begin
                r_response[r_idx] <= r_bit;
                if (!w_last) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign sel_a       = r_sel_a;
    assign sel_b       = r_sel_b;
    assign cnt_clr     = (r_state == CLEAR);
    assign cnt_en      = (r_state == RACE);
    assign busy        = (r_state != IDLE);
    assign resp_valid  = (r_state == DONE);
    assign response    = r_response;
    assign tie         = r_tie;
    assign timeout_err = r_tout;

endmodule

// File: tb/tb_ro_race_arbiter.sv
// Directed bench for ro_race_arbiter: a behavioural counter pair answers each
// race after a fixed delay according to a per-bit winner table.
module tb_ro_race_arbiter;

    localparam int DLY = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] challenge;
    logic       fa;
    logic       fb;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic       cnt_clr;
    logic       cnt_en;
    logic       busy;
    logic [7:0] response;
    logic       resp_valid;
    logic       tie;
    logic       timeout_err;

    always #5 clk = ~clk;

    ro_race_arbiter #(
        .RESP_BITS  (8),
        .SETTLE_CYC (4),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .challenge   (challenge),
        .finished_a  (fa),
        .finished_b  (fb),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .cnt_clr     (cnt_clr),
        .cnt_en      (cnt_en),
        .busy        (busy),
        .response    (response),
        .resp_valid  (resp_valid),
        .tie         (tie),
        .timeout_err (timeout_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Per-bit winner code: 0 none, 1 A, 2 B, 3 both.
    logic [1:0] mode [8];
    bit         stale_b = 1'b0;
    int         bitno, k, n_valid, n_busy, n_overlap, len_min, len_max, n_sel;
    logic [3:0] log_a [16];
    logic [3:0] log_b [16];
    logic       prev_busy, prev_clr;

    initial begin
        fa = 1'b0; fb = 1'b0;
        bitno = 0; k = 0; prev_busy = 1'b0; prev_clr = 1'b0;
        n_valid = 0; n_busy = 0; n_overlap = 0; len_min = 999; len_max = 0; n_sel = 0;
        forever begin
            @(posedge clk); #1;
            if (busy && !prev_busy) begin
                bitno = 0;
                k     = 0;
            end
            if (resp_valid) n_valid++;
            if (busy) n_busy++;
            if (cnt_en && (cnt_clr || !busy)) n_overlap++;
            if (cnt_clr && !prev_clr && n_sel < 16) begin
                log_a[n_sel] = sel_a;
                log_b[n_sel] = sel_b;
                n_sel++;
            end
            if (cnt_en) begin
                fa = (bitno < 8) && mode[bitno][0] && (k == DLY);
                fb = (bitno < 8) && mode[bitno][1] && (k == DLY);
                k++;
            end else begin
                if (k != 0) begin
                    if (k < len_min) len_min = k;
                    if (k > len_max) len_max = k;
                    bitno++;
                    k = 0;
                end
                fa = 1'b0;
                fb = stale_b && busy;
            end
            prev_busy = busy;
            prev_clr  = cnt_clr;
        end
    end

    task automatic clear_stats();
        n_valid = 0; n_busy = 0; n_overlap = 0; len_min = 999; len_max = 0; n_sel = 0;
    endtask

    task automatic set_modes(input logic [15:0] m);
        for (int i = 0; i < 8; i++) mode[i] = m[2*i +: 2];
    endtask

    task automatic kick(input logic [3:0] ch);
        start = 1'b1;
        challenge = ch;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (resp_valid) break;
        end
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    endtask

    task automatic check_sels(input string tag, input logic [31:0] ea, input logic [31:0] eb);
        check({tag, "_nsel"}, n_sel, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_sel_a%0d", tag, i), {28'd0, log_a[i]}, {28'd0, ea[4*i +: 4]});
            check($sformatf("%s_sel_b%0d", tag, i), {28'd0, log_b[i]}, {28'd0, eb[4*i +: 4]});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; challenge = '0;
        set_modes(16'h0000);
        #2;
        check("reset_outs", {10'd0, sel_a, sel_b, response, busy, cnt_clr, cnt_en, resp_valid, tie, timeout_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic race: A wins even bits, B wins odd bits, base 3 wraps at 15.
        clear_stats(); set_modes(16'h9999);
        kick(4'h3);
        wait_done("basic");
        check("basic_resp", {24'd0, response}, 32'h55);
        check("basic_tie", {31'd0, tie}, 32'd0);
        check("basic_tout", {31'd0, timeout_err}, 32'd0);
        repeat (3) @(posedge clk); #1;
        check("basic_nvalid", n_valid, 32'd1);
        check("basic_busy", n_busy, 32'd89);
        check("basic_len", len_max, 32'd4);
        check_sels("basic", 32'h1FDB_9753, 32'h20EC_A864);

        // Simultaneous finish on bit 2 only.
        clear_stats(); set_modes(16'h5575);
        kick(4'h0);
        wait_done("tie");
        check("tie_resp", {24'd0, response}, 32'hFB);
        check("tie_tie", {31'd0, tie}, 32'd1);
        check("tie_tout", {31'd0, timeout_err}, 32'd0);
        repeat (2) @(posedge clk); #1;

        // No finished pulses at all: every bit times out.
        clear_stats(); set_modes(16'h0000);
        kick(4'h0);
        wait_done("tmo");
        check("tmo_resp", {24'd0, response}, 32'h00);
        check("tmo_tout", {31'd0, timeout_err}, 32'd1);
        check("tmo_tie", {31'd0, tie}, 32'd0);
        repeat (2) @(posedge clk); #1;
        check("tmo_busy", n_busy, 32'd185);
        check("tmo_len_min", len_min, 32'd16);
        check("tmo_len_max", len_max, 32'd16);

        // Stale B pulses during CLEAR/SETTLE, A wins every race.
        clear_stats(); set_modes(16'h5555); stale_b = 1'b1;
        kick(4'h0);
        wait_done("stale");
        check("stale_resp", {24'd0, response}, 32'hFF);
        check("stale_tout", {31'd0, timeout_err}, 32'd0);
        check("stale_tie", {31'd0, tie}, 32'd0);
        check("stale_en_out", n_overlap, 32'd0);
        stale_b = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Second start mid-run must be ignored.
        clear_stats(); set_modes(16'h6666);
        kick(4'h8);
        repeat (30) @(posedge clk); #1;
        kick(4'h0);
        wait_done("busy");
        check("busy_resp", {24'd0, response}, 32'hAA);
        repeat (3) @(posedge clk); #1;
        check("busy_nvalid", n_valid, 32'd1);
        check_sels("busy", 32'h6420_ECA8, 32'h7531_FDB9);

        // Asynchronous reset during the race of bit 5.
        clear_stats(); set_modes(16'h5555);
        kick(4'h3);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (bitno == 5 && cnt_en) break;
        end
        check("rst_reach", {31'd0, cnt_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_outs", {10'd0, sel_a, sel_b, response, busy, cnt_clr, cnt_en, resp_valid, tie, timeout_err}, 32'd0);
        repeat (3) @(posedge clk); #1;
        check("rst_nvalid", n_valid, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        clear_stats(); set_modes(16'hA5A5);
        kick(4'h0);
        wait_done("rerun");
        check("rerun_resp", {24'd0, response}, 32'h33);
        repeat (3) @(posedge clk); #1;
        check("rerun_nvalid", n_valid, 32'd1);
        check("rerun_busy", n_busy, 32'd89);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ro_race_arbiter.md
Name: ro_race_arbiter

Overview:
- Controller and consumer for a pair of post-mux ring-oscillator edge counters in the RO-PUF datapath.
- Per response bit, it drives the two mux selects, clears both counters, and enables them together.
- It then waits for the first counter `finished` pulse and records which oscillator reached GOAL first.
- It assembles RESP_BITS such decisions into a response word with a one-cycle valid strobe.

Parameters:
- GOAL, 512: terminal count used by the attached counters; informational, and sets the TIMEOUT default.
- CNT_W, 11: counter value width.
- SEL_W, 4: oscillator mux select width.
- RESP_BITS, 8: response bits per challenge.
- SETTLE_CYC, 4: cycles the mux selects are held stable before enabling the counters.
- TIMEOUT, 8192: maximum RACE cycles per bit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a challenge; ignored while busy
- challenge  in  SEL_W  base oscillator index, captured on an accepted start
- finished_a  in  1  finished pulse from counter A
- finished_b  in  1  finished pulse from counter B
- sel_a  out  SEL_W  mux select for oscillator A
- sel_b  out  SEL_W  mux select for oscillator B
- cnt_clr  out  1  synchronous active-high clear to both counters
- cnt_en  out  1  count enable gate to both counters
- busy  out  1  high from accepted start until resp_valid
- response  out  RESP_BITS  assembled response; bit i is the decision for pair i
- resp_valid  out  1  one-cycle strobe when response is complete
- tie  out  1  sticky per challenge: at least one bit decided by simultaneous finish
- timeout_err  out  1  sticky per challenge: at least one bit hit TIMEOUT

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - All outputs 0, including sel_a, sel_b, response, bit index and timers.
- IDLE:
  - start=1 captures challenge into base and clears tie/timeout_err.
  - response is not cleared here; it is held from the previous challenge until overwritten bit by bit.
  - Sets busy=1, idx=0, then goes to CLEAR.
  - start while busy=1 is ignored, with no side effects.
- Select arithmetic, modulo 2^SEL_W (wrap, no error):
  - sel_a = base + 2*idx
  - sel_b = base + 2*idx + 1
  - Both are registered and change only on entry to CLEAR.
- CLEAR: exactly 2 cycles, cnt_clr=1 and cnt_en=0.
  - The counters' finished output is registered a cycle behind, so finished_a/b are ignored during CLEAR and SETTLE.
- SETTLE: SETTLE_CYC cycles, cnt_clr=0 and cnt_en=0.
- RACE: cnt_en=1, timer counts from 0. Each cycle, evaluated in this priority order:
  - finished_a & finished_b: bit=0, tie<=1.
  - finished_a only: bit=1.
  - finished_b only: bit=0.
  - Neither, and timer==TIMEOUT-1: bit=0, timeout_err<=1.
  - On any of these decisions, go to RECORD the following cycle with cnt_en=0.
- RECORD (1 cycle): response[idx]<=bit.
  - If idx==RESP_BITS-1, go to DONE.
  - Otherwise idx<=idx+1 and go to CLEAR.
- DONE (1 cycle): resp_valid=1, busy<=0, then IDLE.
  - response, tie and timeout_err hold until the next accepted start.
- Latency per bit: 2 + SETTLE_CYC + (race cycles up to and including the deciding cycle) + 1. One extra cycle for DONE.
- Pulses:
  - finished pulses arriving outside RACE are ignored.
  - Only the first decision per bit counts; later pulses in the same bit are discarded.
- Reset mid-operation: immediate return to the reset state, with no resp_valid.
- Internal widths:
  - idx is clog2(RESP_BITS).
  - timer is clog2(TIMEOUT)+1 bits, saturating.

Decomposition:
- Shared package ro_puf_pkg:
  - state enum (IDLE, CLEAR, SETTLE, RACE, RECORD, DONE)
  - CNT_W, SEL_W and GOAL defaults
  - CLEAR_CYC=2
- Sub-module ro_race_timer: loadable saturating down-counter shared by SETTLE and RACE, with a done flag.
- The FSM and datapath stay in ro_race_arbiter.

Test Plan:
- Basic race: challenge=4'h3, RESP_BITS=8; model A faster on even idx, B faster on odd idx.
  - Expect response=8'h55, one resp_valid, tie=0, timeout_err=0.
  - Expect sel_a/sel_b sequence 3/4, 5/6, ..., 1/2 (wrap at 15→0).
- Simultaneous finish: finished_a and finished_b asserted in the same RACE cycle for idx=2.
  - Expect response[2]=0 and tie=1; other bits unaffected.
- Timeout: TIMEOUT=16, no finished pulses at all.
  - Expect each bit to decide at exactly 16 RACE cycles, response=0, timeout_err=1.
  - Expect total busy time = 8*(2+4+16+1)+1 = 185 cycles.
- Stale and early pulses: a finished_b pulse during CLEAR and SETTLE, then finished_a in RACE.
  - Expect bit=1; also check that cnt_en=0 outside RACE.
- Start while busy: a second start with a different challenge mid-run.
  - Expect it ignored, sel_* following the original base, exactly one resp_valid.
- Reset mid-RACE: reset=0 at idx=5.
  - Expect all outputs 0 immediately with no clk edge needed; no resp_valid.
  - A subsequent start must run all 8 bits cleanly.
